// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit before stop.
module uart_rx_fifo #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    input  logic       clr_err
);
    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state, state_n;
    logic            rx_m, rxs;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            bad, bad_n;
    logic            push_req, ferr_set;
    logic            tick, half;
    logic            push, pop;
    logic [FIFO_AW:0] wptr, rptr;
    logic [7:0]      mem [2**FIFO_AW];

    assign tick = (cnt == CW'(BAUD_DIV - 1));
    assign half = (cnt == CW'(BAUD_DIV / 2 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            bad   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            bad   <= bad_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_set;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shreg_n  = shreg;
        bad_n    = bad;
        push_req = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = S_START;
            end
            S_START: begin
                if (half) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    bad_n   = 1'b0;
                    state_n = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    cnt_n   = '0;
                    state_n = S_STOP;
                    if (rxs != ^shreg) begin
                        perr_set = 1'b1;
                        bad_n    = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    cnt_n = '0;
                    if (rxs) begin
                        push_req = !bad;
                        state_n  = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A pop frees the slot in the same cycle, so full+pop still accepts.
    assign pop   = rd_en && !empty;
    assign push  = push_req && (!full || pop);
    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign dout  = empty ? 8'h00 : mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wptr[FIFO_AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set | (frame_err & ~clr_err);
            overrun   <= (push_req & full & ~pop) | (overrun & ~clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= perr_set | (parity_err & ~clr_err);
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=4, FIFO_AW=4.
// Inputs change and outputs are checked on the falling clock edge.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] dout;
    logic       empty, full, frame_err, overrun, parity_err;
    int         nchk = 0;
    int         npass = 0;

    uart_rx_fifo #(.BAUD_DIV(4), .FIFO_AW(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full),
        .frame_err(frame_err), .overrun(overrun),
        .parity_err(parity_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] b, input logic p);
        hold(1'b0, 4);
        for (int i = 0; i < 8; i++) hold(b[i], 4);
        hold(p, 4);
        hold(1'b1, 4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_par(b, ^b);
    endtask
`else
    task automatic send_byte(input logic [7:0] b);
        hold(1'b0, 4);
        for (int i = 0; i < 8; i++) hold(b[i], 4);
        hold(1'b1, 4);
    endtask
`endif

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {31'd0, empty}, 32'd0);
        chk(tag, {24'd0, dout}, {24'd0, exp});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'h00);
        chk("rst_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

        send_byte(8'hA5);
        hold(1'b1, 4);
        pop_chk("a5", 8'hA5);
        chk("a5_drained", {31'd0, empty}, 32'd1);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        hold(1'b1, 4);
        pop_chk("b2b_0", 8'h00);
        pop_chk("b2b_1", 8'hFF);
        pop_chk("b2b_2", 8'h3C);
        chk("b2b_empty", {31'd0, empty}, 32'd1);
        chk("b2b_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        hold(1'b1, 4);
        chk("full16", {31'd0, full}, 32'd1);
        chk("ovr16", {31'd0, overrun}, 32'd0);
        send_byte(8'hEE);
        hold(1'b1, 4);
        chk("ovr17", {31'd0, overrun}, 32'd1);
        chk("full17", {31'd0, full}, 32'd1);
        for (int i = 0; i < 16; i++) pop_chk("fifo_rd", 8'h10 + 8'(i));
        chk("fifo_empty", {31'd0, empty}, 32'd1);
        chk("ovr_kept", {31'd0, overrun}, 32'd1);
        pulse_clr();
        chk("ovr_clr", {31'd0, overrun}, 32'd0);

        rst = 1'b1;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 200);
        chk("brk_ferr", {31'd0, frame_err}, 32'd1);
        chk("brk_empty", {31'd0, empty}, 32'd1);
        pulse_clr();
        hold(1'b0, 200);
        chk("brk_once", {31'd0, frame_err}, 32'd0);
        chk("brk_empty2", {31'd0, empty}, 32'd1);
        hold(1'b1, 8);
        send_byte(8'h5A);
        hold(1'b1, 4);
        pop_chk("after_brk", 8'h5A);
        chk("after_brk_ferr", {31'd0, frame_err}, 32'd0);

        hold(1'b0, 1);
        hold(1'b1, 20);
        chk("glitch_empty", {31'd0, empty}, 32'd1);
        chk("glitch_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

        hold(1'b0, 4);
        for (int i = 0; i < 4; i++) hold(logic'((8'hC3 >> i) & 8'h01), 4);
        hold(1'b1, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 20);
        chk("abort_empty", {31'd0, empty}, 32'd1);
        chk("abort_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        send_byte(8'h81);
        hold(1'b1, 4);
        pop_chk("after_abort", 8'h81);

`ifdef UART_RX_PARITY_EN
        send_par(8'h07, 1'b1);
        hold(1'b1, 4);
        chk("par_ok_err", {31'd0, parity_err}, 32'd0);
        pop_chk("par_ok", 8'h07);
        send_par(8'h07, 1'b0);
        hold(1'b1, 4);
        chk("par_bad_err", {31'd0, parity_err}, 32'd1);
        chk("par_bad_empty", {31'd0, empty}, 32'd1);
        pulse_clr();
        chk("par_clr", {31'd0, parity_err}, 32'd0);
`else
        chk("par_tied", {31'd0, parity_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
